i2c_slave_regfile: RTL

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_filter.sv | 49 ++++
 rtl/i2c_slave_regfile.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared FSM encoding and bus constants for the I2C register-file slave.
// Used by i2c_slave_regfile and its testbench.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser for one I2C line, plus an optional stability filter
// enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    logic s1;
    logic s2;

    // Idle bus level is high, so the synchroniser resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] cnt;

    // Output follows only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (s2 == filt) begin
            cnt  <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            filt <= s2;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end
`else
    assign filt = s2;
`endif

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a DEPTH x 8 register file with an auto-increment pointer.
// Optional line glitch filters are enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         DEPTH      = 16,
    parameter int         FILT_LEN   = 3,
    localparam int        PTR_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_data,
    output logic             busy
);

    logic scl;
    logic sda;
    logic scl_q;
    logic sda_q;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk   (clk),
        .reset (reset),
        .raw   (scl_in),
        .filt  (scl)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk   (clk),
        .reset (reset),
        .raw   (sda_in),
        .filt  (sda)
    );

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

    state_t             state;
    logic [3:0]         bitcnt;
    logic [7:0]         shreg;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               rw;
    logic               mnack;
    logic [7:0]         regs [DEPTH];

    assign ptr_nxt  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign loc_data = regs[loc_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            mnack     <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            scl_q     <= scl;
            sda_q     <= sda;
            wr_strobe <= 1'b0;
            if (start_det) begin
                state  <= ST_ADDR;
                bitcnt <= '0;
                sda_oe <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                bitcnt <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (scl_rise) begin
                if (state inside {ST_ADDR, ST_PTR, ST_WDATA}) begin
                    shreg  <= {shreg[6:0], sda};
                    bitcnt <= bitcnt + 4'd1;
                end else if (state == ST_RDATA) begin
                    bitcnt <= bitcnt + 4'd1;
                end else if (state == ST_RDATA_ACK) begin
                    mnack  <= (sda == NACK);
                end
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR: begin
                        if (bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= ~ACK;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                            end else begin
                                state  <= ST_WAIT_STOP;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        bitcnt <= '0;
                        if (rw) begin
                            state  <= ST_RDATA;
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                        end else begin
                            state  <= ST_PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_PTR: begin
                        if (bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            ptr    <= PTR_W'(32'(shreg) % DEPTH);
                            sda_oe <= ~ACK;
                            state  <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK: begin
                        bitcnt <= '0;
                        sda_oe <= 1'b0;
                        state  <= ST_WDATA;
                    end
                    ST_WDATA: begin
                        // Byte complete: commit and strobe before the ACK slot.
                        if (bitcnt == 4'd8) begin
                            bitcnt     <= '0;
                            regs[ptr]  <= shreg;
                            wr_strobe  <= 1'b1;
                            wr_addr    <= ptr;
                            wr_data    <= shreg;
                            sda_oe     <= ~ACK;
                            state      <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: begin
                        bitcnt <= '0;
                        sda_oe <= 1'b0;
                        ptr    <= ptr_nxt;
                        state  <= ST_WDATA;
                    end
                    ST_RDATA: begin
                        if (bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            sda_oe <= 1'b0;
                            ptr    <= ptr_nxt;
                            state  <= ST_RDATA_ACK;
                        end else if (bitcnt != 4'd0) begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        bitcnt <= '0;
                        if (!mnack) begin
                            state  <= ST_RDATA;
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                        end else begin
                            state  <= ST_WAIT_STOP;
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
